// File: rtl/theta_pkg.sv
// Shared types and constants for the rotational-position tracker.
// Filter build option: THETA_AVG_EN.
package theta_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        LOCKED
    } theta_state_t;

    localparam int THETA_SYNC_STAGES = 2;

endpackage

// File: rtl/period_avg.sv
// Running-sum circular-buffer average of revolution periods.
// Built only when THETA_AVG_EN is defined.
module period_avg #(
    parameter int COUNT_W  = 32,
    parameter int AVG_LOG2 = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               preload,
    input  logic               valid,
    input  logic [COUNT_W-1:0] sample,
    output logic [COUNT_W-1:0] period
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SUM_W = COUNT_W + AVG_LOG2;

    logic [COUNT_W-1:0] hist_q [DEPTH];
    logic [PTR_W-1:0]   wr_q;
    logic [SUM_W-1:0]   sum_q;
    logic [PTR_W-1:0]   wr_next;

    assign wr_next = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            wr_q  <= '0;
            sum_q <= '0;
        end else if (preload) begin
            // Seed every slot so the first average is the fresh sample.
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= sample;
            end
            wr_q  <= '0;
            sum_q <= SUM_W'(sample) << AVG_LOG2;
        end else if (valid) begin
            hist_q[wr_q] <= sample;
            wr_q         <= wr_next;
            sum_q        <= sum_q - SUM_W'(hist_q[wr_q]) + SUM_W'(sample);
        end
    end

    assign period = COUNT_W'(sum_q >> AVG_LOG2);

endmodule

// File: rtl/theta_tracker.sv
// IR index pulse to discretised angle tracker with lock and stall detection.
// Define THETA_AVG_EN to average the period over 2^AVG_LOG2 revolutions.
module theta_tracker
    import theta_pkg::*;
#(
    parameter int COUNT_W         = 32,
    parameter int ROTATIONAL_RES  = 1024,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int AVG_LOG2        = 3,
    parameter int STALL_CYCLES    = 50_000_000
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ir_tripped,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    output logic                              locked,
    output logic [COUNT_W-1:0]                period,
    output logic                              rev_pulse
);

    localparam int RES_W = $clog2(ROTATIONAL_RES);
    localparam logic [RES_W-1:0] DTHETA_MAX = RES_W'(ROTATIONAL_RES - 1);
    localparam logic [COUNT_W-1:0] DEB_LIM = COUNT_W'(DEBOUNCE_CYCLES);
    localparam logic [COUNT_W-1:0] STALL_LIM = COUNT_W'(STALL_CYCLES);
    localparam int S = THETA_SYNC_STAGES;

    logic [S-1:0]       sync_q;
    logic               prev_q;
    logic               mark_q;
    theta_state_t       state_q;
    logic [COUNT_W-1:0] theta_q;
    logic [COUNT_W-1:0] angle_q;
    logic               seen_q;
    logic               accept;
    logic               stall;
    logic               update;
    logic [COUNT_W-1:0] cp_raw;
    logic [COUNT_W-1:0] cp_theta;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            mark_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[S-2:0], ir_tripped};
            prev_q <= sync_q[S-1];
            mark_q <= sync_q[S-1] & ~prev_q;
        end
    end

    assign accept = mark_q && (!seen_q || theta_q >= DEB_LIM);
    assign stall  = (state_q != IDLE) && (theta_q == STALL_LIM) && !accept;
    assign update = accept && (state_q == LOCKED);

`ifdef THETA_AVG_EN
    logic preload;

    assign preload = accept && (state_q == SYNC);

    period_avg #(
        .COUNT_W (COUNT_W),
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk    (clk_in),
        .rst_n  (rst_in),
        .preload(preload),
        .valid  (update),
        .sample (theta_q),
        .period (period)
    );
`else
    logic               capture;
    logic [COUNT_W-1:0] sample_q;

    assign capture = accept && (state_q != IDLE);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sample_q <= '0;
        end else if (capture) begin
            sample_q <= theta_q;
        end
    end

    assign period = sample_q;
`endif

    // A zero step would never advance the angle on very fast rotation.
    assign cp_raw   = period >> RES_W;
    assign cp_theta = (cp_raw == '0) ? COUNT_W'(1) : cp_raw;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            theta_q   <= '0;
            seen_q    <= 1'b0;
            angle_q   <= '0;
            dtheta    <= '0;
            locked    <= 1'b0;
            rev_pulse <= 1'b0;
        end else begin
            rev_pulse <= update;
            if (accept) begin
                theta_q <= '0;
                seen_q  <= 1'b1;
            end else if (theta_q != '1) begin
                theta_q <= theta_q + 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    locked  <= 1'b0;
                    dtheta  <= '0;
                    angle_q <= '0;
                    if (accept) begin
                        state_q <= SYNC;
                    end
                end
                SYNC: begin
                    dtheta  <= '0;
                    angle_q <= '0;
                    if (accept) begin
                        state_q <= LOCKED;
                        locked  <= 1'b1;
                    end else if (stall) begin
                        state_q <= IDLE;
                        locked  <= 1'b0;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        dtheta  <= '0;
                        angle_q <= '0;
                    end else if (stall) begin
                        state_q <= IDLE;
                        locked  <= 1'b0;
                        dtheta  <= '0;
                        angle_q <= '0;
                    end else if (angle_q == cp_theta - COUNT_W'(1)) begin
                        angle_q <= '0;
                        // Hold at the last step until the next index mark.
                        if (dtheta != DTHETA_MAX) begin
                            dtheta <= dtheta + 1'b1;
                        end
                    end else begin
                        angle_q <= angle_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    locked  <= 1'b0;
                    dtheta  <= '0;
                    angle_q <= '0;
                end
            endcase
        end
    end

endmodule
